// File: rtl/rr_pkg.sv
// Shared constants, command/tag types and kernel-index helpers for the
// round-robin scheduling kernels and the grant router.
package rr_pkg;

  localparam int NCONSUMERS   = 8;
  localparam int NBANKS       = 4;
  localparam int NPORTS       = 2;
  localparam int ADDR_WIDTH   = 12;
  localparam int DATA_WIDTH   = 32;
  localparam int BANK_LATENCY = 2;

  localparam int NKERNELS = NBANKS * NPORTS;
  localparam int CID_W    = $clog2(NCONSUMERS);
  localparam int BANK_W   = $clog2(NBANKS);
  localparam int BADDR_W  = ADDR_WIDTH - BANK_W;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [BADDR_W-1:0]    baddr;
    logic [DATA_WIDTH-1:0] wdata;
  } bank_cmd_t;

  typedef struct packed {
    logic             valid;
    logic [CID_W-1:0] cid;
  } rd_tag_t;

  function automatic logic [BANK_W-1:0] kernel_bank(input int k);
    return BANK_W'(k / NPORTS);
  endfunction

  function automatic int kernel_port(input int k);
    return k % NPORTS;
  endfunction

endpackage

// File: rtl/rr_read_tag_pipe.sv
// Delays a read tag by DEPTH cycles so it lines up with the bank's read data.
module rr_read_tag_pipe
  import rr_pkg::*;
#(
  parameter int DEPTH = BANK_LATENCY
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rr_grant_router.sv
// Validates per-kernel grants, registers bank-port commands and routes read
// data from the bank ports back to the consumer that issued the read.
module rr_grant_router
  import rr_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NKERNELS-1:0]              grant_valid_i,
  input  logic [NKERNELS*CID_W-1:0]        grant_id_i,
  input  logic [NCONSUMERS-1:0]            req_valid_i,
  input  logic [NCONSUMERS-1:0]            req_we_i,
  input  logic [NCONSUMERS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NCONSUMERS*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NCONSUMERS-1:0]            ack_o,
  output logic [NCONSUMERS-1:0]            rdata_valid_o,
  output logic [NCONSUMERS*DATA_WIDTH-1:0] rdata_o,
  output logic [NKERNELS-1:0]              bank_en_o,
  output logic [NKERNELS-1:0]              bank_we_o,
  output logic [NKERNELS*BADDR_W-1:0]      bank_addr_o,
  output logic [NKERNELS*DATA_WIDTH-1:0]   bank_wdata_o,
  input  logic [NKERNELS*DATA_WIDTH-1:0]   bank_rdata_i,
  output logic                             grant_err_o
);

  logic [CID_W-1:0]      kid     [NKERNELS];
  logic [NKERNELS-1:0]   legal;
  logic [NCONSUMERS-1:0] ack_next;
  logic [NCONSUMERS-1:0] claimed;
  logic                  err_next;
  bank_cmd_t             cmd_r   [NKERNELS];
  logic [CID_W-1:0]      cid_r   [NKERNELS];
  rd_tag_t               tag_in  [NKERNELS];
  rd_tag_t               tag_out [NKERNELS];
  logic [NCONSUMERS-1:0] hit;
  logic [DATA_WIDTH-1:0] ret     [NCONSUMERS];

  for (genvar k = 0; k < NKERNELS; k++) begin : g_kernel
    assign kid[k]                                = grant_id_i[k*CID_W +: CID_W];
    assign bank_en_o[k]                          = cmd_r[k].en;
    assign bank_we_o[k]                          = cmd_r[k].we;
    assign bank_addr_o[k*BADDR_W +: BADDR_W]     = cmd_r[k].baddr;
    assign bank_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] = cmd_r[k].wdata;
    assign tag_in[k] = '{valid: cmd_r[k].en & ~cmd_r[k].we, cid: cid_r[k]};

    rr_read_tag_pipe #(.DEPTH(BANK_LATENCY)) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in[k]),
      .tag_out (tag_out[k])
    );
  end

  // Any grant to a consumer already granted by a lower kernel loses, legal or not.
  always_comb begin
    legal    = '0;
    ack_next = '0;
    claimed  = '0;
    err_next = 1'b0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (grant_valid_i[k]) begin
        if (int'(kid[k]) < NCONSUMERS && req_valid_i[kid[k]] && !ack_o[kid[k]] &&
            !claimed[kid[k]] &&
            req_addr_i[int'(kid[k])*ADDR_WIDTH + BADDR_W +: BANK_W] == kernel_bank(k)) begin
          legal[k]          = 1'b1;
          ack_next[kid[k]]  = 1'b1;
        end else begin
          err_next = 1'b1;
        end
        if (int'(kid[k]) < NCONSUMERS) claimed[kid[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NKERNELS; k++) begin
        cmd_r[k] <= '0;
        cid_r[k] <= '0;
      end
      ack_o       <= '0;
      grant_err_o <= 1'b0;
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        cmd_r[k].en    <= legal[k];
        cmd_r[k].we    <= legal[k] & req_we_i[kid[k]];
        cmd_r[k].baddr <= req_addr_i[int'(kid[k])*ADDR_WIDTH +: BADDR_W];
        cmd_r[k].wdata <= req_wdata_i[int'(kid[k])*DATA_WIDTH +: DATA_WIDTH];
        cid_r[k]       <= kid[k];
      end
      ack_o       <= ack_next;
      grant_err_o <= grant_err_o | err_next;
    end
  end

  // At most one tag per consumer matures in a cycle, so OR-merging is exact.
  always_comb begin
    hit = '0;
    for (int c = 0; c < NCONSUMERS; c++) ret[c] = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (tag_out[k].valid) begin
        hit[tag_out[k].cid] = 1'b1;
        ret[tag_out[k].cid] = ret[tag_out[k].cid] | bank_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_valid_o <= '0;
      rdata_o       <= '0;
    end else begin
      rdata_valid_o <= hit;
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (hit[c]) rdata_o[c*DATA_WIDTH +: DATA_WIDTH] <= ret[c];
      end
    end
  end

endmodule

// File: tb/tb_rr_grant_router.sv
// Directed self-checking bench for rr_grant_router (bank latency 2).
module tb_rr_grant_router;
  import rr_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    grant_valid;
  logic [23:0]   grant_id;
  logic [7:0]    req_valid;
  logic [7:0]    req_we;
  logic [95:0]   req_addr;
  logic [255:0]  req_wdata;
  logic [7:0]    ack_o;
  logic [7:0]    rdata_valid_o;
  logic [255:0]  rdata_o;
  logic [7:0]    bank_en_o;
  logic [7:0]    bank_we_o;
  logic [79:0]   bank_addr_o;
  logic [255:0]  bank_wdata_o;
  logic [255:0]  bank_rdata;
  logic          grant_err_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rr_grant_router dut (
    .clk           (clk),
    .reset         (reset),
    .grant_valid_i (grant_valid),
    .grant_id_i    (grant_id),
    .req_valid_i   (req_valid),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .ack_o         (ack_o),
    .rdata_valid_o (rdata_valid_o),
    .rdata_o       (rdata_o),
    .bank_en_o     (bank_en_o),
    .bank_we_o     (bank_we_o),
    .bank_addr_o   (bank_addr_o),
    .bank_wdata_o  (bank_wdata_o),
    .bank_rdata_i  (bank_rdata),
    .grant_err_o   (grant_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    grant_valid = '0; grant_id = '0; req_valid = '0; req_we = '0;
    req_addr = '0; req_wdata = '0; bank_rdata = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int c, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    req_valid[c] = 1'b1;
    req_we[c] = we;
    req_addr[c*12 +: 12] = addr;
    req_wdata[c*32 +: 32] = wd;
  endtask

  task automatic set_grant(input int k, input int c);
    grant_valid[k] = 1'b1;
    grant_id[k*3 +: 3] = 3'(c);
  endtask

  function automatic logic [31:0] rd_word(input int i, input int c);
    return 32'hC0DE0000 | 32'(i << 8) | 32'(c);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      grant_valid = 8'($urandom);
      grant_id = 24'($urandom);
      req_valid = 8'($urandom);
      req_we = 8'($urandom);
      for (int c = 0; c < 8; c++) begin
        req_addr[c*12 +: 12] = 12'($urandom);
        req_wdata[c*32 +: 32] = $urandom;
      end
      bank_rdata = {8{$urandom}};
      tick();
      vectors++;
      if ({ack_o, rdata_valid_o, bank_en_o, bank_we_o, grant_err_o} !== 33'd0) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d: ack=%h rv=%h en=%h we=%h err=%b, expected all 0",
                 n, ack_o, rdata_valid_o, bank_en_o, bank_we_o, grant_err_o);
      end
      vectors++;
      if (rdata_o !== 256'd0 || bank_addr_o !== 80'd0 || bank_wdata_o !== 256'd0) begin
        errors++;
        $display("FAIL reset_data cycle %0d: rdata/addr/wdata not zero", n);
      end
    end
    reset = 1'b0;
    clear_inputs();
    for (int n = 0; n < 4; n++) begin
      bank_rdata = {8{32'hFFFFFFFF}};
      tick();
      vectors++;
      if (rdata_valid_o !== 8'h00 || grant_err_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: rv=%h err=%b, expected 00/0", n, rdata_valid_o, grant_err_o);
      end
    end
  endtask

  task automatic test_read();
    apply_reset();
    set_req(3, 1'b0, 12'h405, 32'h0);
    set_grant(2, 3);
    tick();
    vectors++;
    if (bank_en_o !== 8'h04 || bank_we_o !== 8'h00) begin
      errors++;
      $display("FAIL read_cmd: en=%h we=%h, expected 04/00", bank_en_o, bank_we_o);
    end
    vectors++;
    if (bank_addr_o[20 +: 10] !== 10'h005) begin
      errors++;
      $display("FAIL read_addr: got %h expected 005", bank_addr_o[20 +: 10]);
    end
    vectors++;
    if (ack_o !== 8'h08 || grant_err_o !== 1'b0) begin
      errors++;
      $display("FAIL read_ack: ack=%h err=%b, expected 08/0", ack_o, grant_err_o);
    end
    clear_inputs();
    tick();
    tick();
    bank_rdata[64 +: 32] = 32'hDEADBEEF;
    vectors++;
    if (rdata_valid_o !== 8'h00) begin
      errors++;
      $display("FAIL read_early: rv=%h expected 00", rdata_valid_o);
    end
    tick();
    bank_rdata = '0;
    vectors++;
    if (rdata_valid_o !== 8'h08 || rdata_o[96 +: 32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_return: rv=%h data=%h, expected 08/deadbeef", rdata_valid_o, rdata_o[96 +: 32]);
    end
    tick();
    vectors++;
    if (rdata_valid_o !== 8'h00 || rdata_o[96 +: 32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_hold: rv=%h data=%h, expected 00/deadbeef", rdata_valid_o, rdata_o[96 +: 32]);
    end
  endtask

  task automatic test_write();
    apply_reset();
    set_req(0, 1'b1, 12'hC12, 32'hA5A5A5A5);
    set_grant(7, 0);
    tick();
    vectors++;
    if (bank_en_o !== 8'h80 || bank_we_o !== 8'h80 || ack_o !== 8'h01) begin
      errors++;
      $display("FAIL write_cmd: en=%h we=%h ack=%h, expected 80/80/01", bank_en_o, bank_we_o, ack_o);
    end
    vectors++;
    if (bank_wdata_o[224 +: 32] !== 32'hA5A5A5A5 || bank_addr_o[70 +: 10] !== 10'h012) begin
      errors++;
      $display("FAIL write_data: wdata=%h addr=%h, expected a5a5a5a5/012",
               bank_wdata_o[224 +: 32], bank_addr_o[70 +: 10]);
    end
    clear_inputs();
    for (int n = 0; n < 6; n++) begin
      bank_rdata = {8{32'h13579BDF}};
      tick();
      vectors++;
      if (rdata_valid_o !== 8'h00) begin
        errors++;
        $display("FAIL write_noreturn cycle %0d: rv=%h expected 00", n, rdata_valid_o);
      end
    end
  endtask

  task automatic test_double_grant();
    apply_reset();
    set_req(5, 1'b0, 12'h033, 32'h0);
    set_grant(0, 5);
    set_grant(1, 5);
    tick();
    vectors++;
    if (bank_en_o !== 8'h01 || ack_o !== 8'h20 || grant_err_o !== 1'b1) begin
      errors++;
      $display("FAIL double_grant: en=%h ack=%h err=%b, expected 01/20/1", bank_en_o, ack_o, grant_err_o);
    end
    clear_inputs();
    tick();
    vectors++;
    if (ack_o !== 8'h00) begin
      errors++;
      $display("FAIL double_ack_once: ack=%h expected 00", ack_o);
    end
    tick();
    bank_rdata[0 +: 32] = 32'h5555AAAA;
    bank_rdata[32 +: 32] = 32'h12345678;
    tick();
    bank_rdata = '0;
    vectors++;
    if (rdata_valid_o !== 8'h20 || rdata_o[160 +: 32] !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL double_return: rv=%h data=%h, expected 20/5555aaaa", rdata_valid_o, rdata_o[160 +: 32]);
    end
    vectors++;
    if (grant_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b expected 1", grant_err_o);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    set_req(2, 1'b0, 12'h011, 32'h0);
    set_grant(4, 2);
    tick();
    vectors++;
    if (bank_en_o !== 8'h00 || ack_o !== 8'h00 || grant_err_o !== 1'b1) begin
      errors++;
      $display("FAIL bank_mismatch: en=%h ack=%h err=%b, expected 00/00/1", bank_en_o, ack_o, grant_err_o);
    end
    apply_reset();
    req_addr[24 +: 12] = 12'h811;
    set_grant(4, 2);
    tick();
    vectors++;
    if (bank_en_o !== 8'h00 || ack_o !== 8'h00 || grant_err_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_consumer: en=%h ack=%h err=%b, expected 00/00/1", bank_en_o, ack_o, grant_err_o);
    end
    apply_reset();
    set_req(1, 1'b0, 12'h001, 32'h0);
    set_grant(0, 1);
    tick();
    vectors++;
    if (bank_en_o !== 8'h01 || ack_o !== 8'h02 || grant_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reaccept_first: en=%h ack=%h err=%b, expected 01/02/0", bank_en_o, ack_o, grant_err_o);
    end
    tick();
    vectors++;
    if (bank_en_o !== 8'h00 || ack_o !== 8'h00 || grant_err_o !== 1'b1) begin
      errors++;
      $display("FAIL reaccept_second: en=%h ack=%h err=%b, expected 00/00/1", bank_en_o, ack_o, grant_err_o);
    end
    clear_inputs();
  endtask

  // Cycle i: consumers j+4*(i%2) read via kernel 2j+((i>>1)&1); reset in cycle 10.
  task automatic test_throughput();
    logic [7:0]  emask;
    logic [7:0]  cmask;
    logic [11:0] a;
    int c;
    int k;
    apply_reset();
    for (int n = 0; n <= 16; n++) begin
      if (n >= 1 && n <= 10) begin
        emask = ((((n - 1) >> 1) & 1) == 1) ? 8'hAA : 8'h55;
        cmask = (((n - 1) % 2) == 1) ? 8'hF0 : 8'h0F;
        vectors++;
        if (bank_en_o !== emask || ack_o !== cmask) begin
          errors++;
          $display("FAIL tput_issue cycle %0d: en=%h ack=%h, expected %h/%h", n, bank_en_o, ack_o, emask, cmask);
        end
      end
      if (n >= 4 && n <= 10) begin
        cmask = (((n - 4) % 2) == 1) ? 8'hF0 : 8'h0F;
        vectors++;
        if (rdata_valid_o !== cmask) begin
          errors++;
          $display("FAIL tput_rvalid cycle %0d: rv=%h expected %h", n, rdata_valid_o, cmask);
        end
        for (int j = 0; j < 4; j++) begin
          c = j + 4 * ((n - 4) % 2);
          vectors++;
          if (rdata_o[c*32 +: 32] !== rd_word(n - 4, c)) begin
            errors++;
            $display("FAIL tput_rdata cycle %0d c%0d: got %h expected %h", n, c, rdata_o[c*32 +: 32], rd_word(n - 4, c));
          end
        end
      end else begin
        vectors++;
        if (rdata_valid_o !== 8'h00) begin
          errors++;
          $display("FAIL tput_quiet cycle %0d: rv=%h expected 00", n, rdata_valid_o);
        end
      end
      clear_inputs();
      reset = (n == 10);
      if (n < 10) begin
        for (int j = 0; j < 4; j++) begin
          c = j + 4 * (n % 2);
          k = 2 * j + ((n >> 1) & 1);
          a = {2'(j), 10'(n * 16 + c)};
          set_req(c, 1'b0, a, 32'h0);
          set_grant(k, c);
        end
      end
      if (n >= 3 && n <= 12) begin
        for (int j = 0; j < 4; j++) begin
          c = j + 4 * ((n - 3) % 2);
          k = 2 * j + (((n - 3) >> 1) & 1);
          bank_rdata[k*32 +: 32] = rd_word(n - 3, c);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_read();
    test_write();
    test_double_grant();
    test_illegal();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
